// File: rtl/inst_axi_bridge.sv
// inst_axi_bridge: one-entry instruction buffer in front of an AXI-Lite read master for the core fetch stage.
// Latency: a hit returns data combinationally; a miss needs at least 3 cycles (miss, AR, R) and hits in the 4th.
// Backpressure: stall_req_o holds the core while AR waits on m_arready and R waits on m_rvalid; one read outstanding.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rom_ce_i, rom_addr_i  fetch request from the PC stage
//   rom_data_o            instruction word (0/NOP unless the buffer hits)
//   stall_req_o           fetch not satisfied this cycle
//   m_ar*, m_r*           AXI-Lite read address / read data channels
//   err_o                 sticky bus-error flag
// Option: define INST_BRIDGE_RESP_CHECK_EN to turn a non-OKAY rresp into a zero fill plus sticky err_o;
//         without it rresp is ignored and err_o is tied low.
module inst_axi_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rom_ce_i,
   input  logic [ADDR_WIDTH-1:0] rom_addr_i,
   output logic [DATA_WIDTH-1:0] rom_data_o,
   output logic                  stall_req_o,
   output logic [ADDR_WIDTH-1:0] m_araddr,
   output logic [2:0]            m_arprot,
   output logic                  m_arvalid,
   input  logic                  m_arready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic [1:0]            m_rresp,
   input  logic                  m_rvalid,
   output logic                  m_rready,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  vld_q, vld_d;
   logic                  hit;
   logic [DATA_WIDTH-1:0] fill_data;

`ifdef INST_BRIDGE_RESP_CHECK_EN
   logic err_q, err_d;
   logic fill_err;
   assign fill_err  = (m_rresp != 2'b00);
   // A failed read still fills the entry, but with a NOP so the core never executes garbage.
   assign fill_data = fill_err ? '0 : m_rdata;
   assign err_o     = err_q;
`else
   logic unused_rresp;
   assign unused_rresp = ^m_rresp;
   assign fill_data    = m_rdata;
   assign err_o        = 1'b0;
`endif

   // Hits are only honoured in IDLE so the buffer is never read while it is being refilled.
   assign hit         = rom_ce_i & vld_q & (rom_addr_i == tag_q) & (state_q == IDLE);
   assign rom_data_o  = hit ? data_q : '0;
   assign stall_req_o = rom_ce_i & ~hit;
   // addr_q only changes when leaving IDLE, so araddr is stable for the whole AR phase.
   assign m_araddr    = addr_q;
   assign m_arprot    = 3'b100;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tag_d     = tag_q;
      data_d    = data_q;
      vld_d     = vld_q;
`ifdef INST_BRIDGE_RESP_CHECK_EN
      err_d     = err_q;
`endif
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rom_ce_i && !hit) begin
               state_d = ADDR;
               addr_d  = rom_addr_i;
            end
         end
         ADDR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            m_rready = 1'b1;
            // The fill completes even if the core dropped rom_ce_i or moved on to another address.
            if (m_rvalid) begin
               state_d = IDLE;
               tag_d   = addr_q;
               data_d  = fill_data;
               vld_d   = 1'b1;
`ifdef INST_BRIDGE_RESP_CHECK_EN
               if (fill_err) begin
                  err_d = 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         tag_q   <= '0;
         data_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
      end
   end

`ifdef INST_BRIDGE_RESP_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// tb_inst_axi_bridge: directed bench for inst_axi_bridge acting as core fetch stage and AXI-Lite slave.
// Expected araddr values are queued when a miss is driven; expected fill words are queued when rdata is driven.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
module tb_inst_axi_bridge;

`ifdef INST_BRIDGE_RESP_CHECK_EN
   localparam bit ERR_CHECK = 1'b1;
`else
   localparam bit ERR_CHECK = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        stall_req_o;
   logic [31:0] m_araddr;
   logic [2:0]  m_arprot;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rvalid;
   logic        m_rready;
   logic        err_o;

   int          checks;
   int          errors;
   logic [31:0] ar_q[$];
   logic [31:0] data_exp_q[$];
   logic [31:0] last_data;
   logic [31:0] a_tmp;

   inst_axi_bridge #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rom_ce_i   (rom_ce_i),
      .rom_addr_i (rom_addr_i),
      .rom_data_o (rom_data_o),
      .stall_req_o(stall_req_o),
      .m_araddr   (m_araddr),
      .m_arprot   (m_arprot),
      .m_arvalid  (m_arvalid),
      .m_arready  (m_arready),
      .m_rdata    (m_rdata),
      .m_rresp    (m_rresp),
      .m_rvalid   (m_rvalid),
      .m_rready   (m_rready),
      .err_o      (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fill_exp(input logic [31:0] rd, input logic [1:0] rs);
      if (ERR_CHECK && (rs != 2'b00)) return 32'h0;
      return rd;
   endfunction

   // First cycle of a miss: request is visible, bridge stalls, no AR yet.
   task automatic miss_cycle(input string tag, input logic [31:0] a);
      @(negedge clk);
      rom_ce_i   = 1'b1;
      rom_addr_i = a;
      m_arready  = 1'b0;
      m_rvalid   = 1'b0;
      #1;
      check1({tag, "_miss_stall"}, stall_req_o, 1'b1);
      check1({tag, "_miss_arvalid"}, m_arvalid, 1'b0);
      check32({tag, "_miss_data"}, rom_data_o, 32'h0);
      ar_q.push_back(a);
   endtask

   // AR phase held for ar_dly extra cycles, R phase for r_dly extra cycles; last R cycle carries rvalid.
   task automatic serve(input string tag, input int ar_dly, input int r_dly,
                        input logic [31:0] rd, input logic [1:0] rs,
                        input logic ce_fly, input logic [31:0] addr_fly, input bit push_exp);
      logic [31:0] exp_a;
      if (ar_q.size() != 0) exp_a = ar_q.pop_front();
      else                  exp_a = 32'hxxxx_xxxx;
      for (int i = 0; i <= ar_dly; i++) begin
         @(negedge clk);
         rom_ce_i  = ce_fly;
         m_arready = (i == ar_dly);
         #1;
         check1({tag, "_ar_arvalid"}, m_arvalid, 1'b1);
         check32({tag, "_ar_araddr"}, m_araddr, exp_a);
         check1({tag, "_ar_rready"}, m_rready, 1'b0);
         check1({tag, "_ar_stall"}, stall_req_o, ce_fly);
      end
      for (int i = 0; i <= r_dly; i++) begin
         @(negedge clk);
         m_arready  = 1'b0;
         rom_addr_i = addr_fly;
         m_rvalid   = (i == r_dly);
         m_rdata    = rd;
         m_rresp    = rs;
         #1;
         check1({tag, "_r_rready"}, m_rready, 1'b1);
         check1({tag, "_r_arvalid"}, m_arvalid, 1'b0);
         check32({tag, "_r_araddr"}, m_araddr, exp_a);
         check1({tag, "_r_stall"}, stall_req_o, ce_fly);
         check32({tag, "_r_data"}, rom_data_o, 32'h0);
      end
      if (push_exp) data_exp_q.push_back(fill_exp(rd, rs));
   endtask

   task automatic expect_hit(input string tag);
      logic [31:0] e;
      if (data_exp_q.size() != 0) e = data_exp_q.pop_front();
      else                        e = 32'hxxxx_xxxx;
      check32({tag, "_hit_data"}, rom_data_o, e);
      check1({tag, "_hit_stall"}, stall_req_o, 1'b0);
      check1({tag, "_hit_arvalid"}, m_arvalid, 1'b0);
      check1({tag, "_hit_rready"}, m_rready, 1'b0);
      last_data = e;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      rst        = 1'b1;
      rom_ce_i   = 1'b0;
      rom_addr_i = 32'h0;
      m_arready  = 1'b0;
      m_rdata    = 32'h0;
      m_rresp    = 2'b00;
      m_rvalid   = 1'b0;
      last_data  = 32'h0;

      // Reset state, then stall follows ce combinationally while still in reset.
      @(negedge clk);
      @(negedge clk);
      #1;
      check1("rst_arvalid", m_arvalid, 1'b0);
      check1("rst_rready", m_rready, 1'b0);
      check32("rst_araddr", m_araddr, 32'h0);
      check1("rst_stall_ce0", stall_req_o, 1'b0);
      check32("rst_data", rom_data_o, 32'h0);
      check1("rst_err", err_o, 1'b0);
      check32("arprot", {29'b0, m_arprot}, 32'h4);
      rom_ce_i = 1'b1;
      #1;
      check1("rst_stall_ce1", stall_req_o, 1'b1);
      check32("rst_data_ce1", rom_data_o, 32'h0);

      // Idle with ce low: no traffic, no stall.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         rst      = 1'b0;
         rom_ce_i = 1'b0;
         #1;
         check1("idle_stall", stall_req_o, 1'b0);
         check1("idle_arvalid", m_arvalid, 1'b0);
         check32("idle_data", rom_data_o, 32'h0);
      end

      // Cold miss at 0x0 with immediate arready/rvalid: hit in the fourth cycle.
      miss_cycle("cold", 32'h0000_0000);
      serve("cold", 0, 0, 32'h3401_0020, 2'b00, 1'b1, 32'h0000_0000, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      expect_hit("cold");

      // Held address keeps hitting with no bus traffic.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check32("hold_data", rom_data_o, last_data);
         check1("hold_stall", stall_req_o, 1'b0);
         check1("hold_arvalid", m_arvalid, 1'b0);
      end

      // ce low in IDLE with a valid entry: output is NOP, no stall.
      @(negedge clk);
      rom_ce_i = 1'b0;
      #1;
      check32("ce0_data", rom_data_o, 32'h0);
      check1("ce0_stall", stall_req_o, 1'b0);

      // Backpressure: arready 4 cycles late, rvalid 3 cycles late.
      miss_cycle("bp", 32'h0000_0004);
      serve("bp", 4, 3, 32'h1111_0004, 2'b00, 1'b1, 32'h0000_0004, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      expect_hit("bp");

      // ce dropped during the transaction: fill still completes.
      miss_cycle("cedrop", 32'h0000_0020);
      serve("cedrop", 1, 1, 32'h2020_2020, 2'b00, 1'b0, 32'h0000_0020, 1'b1);
      @(negedge clk);
      m_rvalid   = 1'b0;
      rom_ce_i   = 1'b1;
      rom_addr_i = 32'h0000_0020;
      #1;
      expect_hit("cedrop");

      // Address switches 0x4 -> 0x8 in DATA: 0x4 fill finishes, then a fresh fetch of 0x8.
      miss_cycle("sw4", 32'h0000_0004);
      serve("sw4", 0, 1, 32'h4444_0004, 2'b00, 1'b1, 32'h0000_0008, 1'b0);
      miss_cycle("sw8", 32'h0000_0008);
      serve("sw8", 1, 0, 32'h8888_0008, 2'b00, 1'b1, 32'h0000_0008, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      expect_hit("sw8");

      // Reset while waiting for rvalid: transaction abandoned, buffer invalidated.
      miss_cycle("rmf", 32'h0000_0030);
      a_tmp = ar_q.pop_front();
      @(negedge clk);
      m_arready = 1'b1;
      #1;
      check1("rmf_arvalid", m_arvalid, 1'b1);
      check32("rmf_araddr", m_araddr, a_tmp);
      @(negedge clk);
      m_arready = 1'b0;
      #1;
      check1("rmf_rready", m_rready, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      rom_addr_i = 32'h0000_0008;
      #1;
      check1("rmf_post_arvalid", m_arvalid, 1'b0);
      check1("rmf_post_rready", m_rready, 1'b0);
      check32("rmf_post_araddr", m_araddr, 32'h0);
      check1("rmf_post_stall", stall_req_o, 1'b1);
      check32("rmf_post_data", rom_data_o, 32'h0);
      ar_q.push_back(32'h0000_0008);
      serve("refetch", 0, 0, 32'h8888_1008, 2'b00, 1'b1, 32'h0000_0008, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      expect_hit("refetch");

      // Error response: zero fill and sticky err_o when checking is built in.
      miss_cycle("err", 32'h0000_0040);
      serve("err", 0, 0, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h0000_0040, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      m_rresp  = 2'b00;
      #1;
      expect_hit("err");
      check1("err_flag", err_o, ERR_CHECK);
      miss_cycle("okafter", 32'h0000_0044);
      serve("okafter", 0, 0, 32'h5555_0044, 2'b00, 1'b1, 32'h0000_0044, 1'b1);
      @(negedge clk);
      m_rvalid = 1'b0;
      #1;
      expect_hit("okafter");
      check1("err_sticky", err_o, ERR_CHECK);

      // Final reset clears the error flag and the buffer.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check1("final_err", err_o, 1'b0);
      check32("final_data", rom_data_o, 32'h0);
      check1("final_stall", stall_req_o, 1'b1);

      check32("queues_drained", ar_q.size() + data_exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_axi_bridge.md
INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the instruction address and AXI araddr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word and AXI rdata width.
REQ-003 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rom_ce_i  in  1  fetch enable from the core PC stage.
REQ-007 rom_addr_i  in  ADDR_WIDTH  fetch address from the core.
REQ-008 rom_data_o  out  DATA_WIDTH  instruction word returned to the core.
REQ-009 stall_req_o  out  1  fetch not yet satisfied; the core holds PC and IF/ID.
REQ-010 m_araddr  out  ADDR_WIDTH  AXI-Lite read address.
REQ-011 m_arprot  out  3  AXI-Lite protection, constant 3'b100 (instruction, secure, unprivileged).
REQ-012 m_arvalid  out  1 / m_arready  in  1  AXI-Lite read-address handshake.
REQ-013 m_rdata  in  DATA_WIDTH / m_rresp  in  2  AXI-Lite read data and response.
REQ-014 m_rvalid  in  1 / m_rready  out  1  AXI-Lite read-data handshake.
REQ-015 err_o  out  1  sticky bus-error flag (see Configuration).

Function
REQ-016 The block SHALL hold a one-entry buffer: tag_q (ADDR_WIDTH), data_q (DATA_WIDTH), vld_q (1).
REQ-017 hit SHALL be defined as rom_ce_i & vld_q & (rom_addr_i == tag_q) & (state == IDLE).
REQ-018 rom_data_o SHALL equal data_q when hit, else 0 (NOP); it is combinational.
REQ-019 stall_req_o SHALL equal rom_ce_i & ~hit, combinationally, in the same cycle.
REQ-020 The FSM SHALL have three states: IDLE, ADDR and DATA.
REQ-021 IDLE -> ADDR SHALL occur when rom_ce_i & ~hit; addr_q <= rom_addr_i on that edge.
REQ-022 In ADDR, m_arvalid=1 and m_araddr=addr_q, both stable until m_arready; ADDR -> DATA on m_arvalid & m_arready.
REQ-023 In DATA, m_rready=1; DATA -> IDLE on m_rvalid; on that edge tag_q<=addr_q, data_q<=m_rdata, vld_q<=1.
REQ-024 m_arvalid SHALL be 0 outside ADDR and m_rready 0 outside DATA; at most one transaction is outstanding.
REQ-025 Minimum miss latency: miss seen in cycle N; arvalid high in N+1; with arready in N+1 and rvalid in N+2, hit (stall_req_o=0) in N+3.
REQ-026 rom_ce_i deasserting in ADDR or DATA SHALL NOT abort the transaction; it completes and the buffer is filled.
REQ-027 A rom_addr_i change during ADDR/DATA SHALL NOT alter m_araddr; after fill, a tag mismatch starts a new fetch from IDLE.
REQ-028 With rom_ce_i=0 in IDLE, the FSM SHALL stay in IDLE, and stall_req_o=0, rom_data_o=0.
REQ-029 Address wrap SHALL be treated as a plain tag compare; there is no sequential prefetch.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, vld_q=0, tag_q=0, data_q=0, addr_q=0, err_o=0.
REQ-031 After that reset edge: m_arvalid=0, m_rready=0, m_araddr=0; combinationally, stall_req_o=rom_ce_i and rom_data_o=0.
REQ-032 Reset mid-transaction SHALL abandon it with no buffer fill; the interconnect is reset on the same rst.

Configuration
REQ-033 Macro INST_BRIDGE_RESP_CHECK_EN SHALL control bus-error handling.
REQ-034 With the macro defined, an rresp != 2'b00 at fill SHALL load data_q=0 and set err_o=1 until reset; tag_q and vld_q are updated as normal.
REQ-035 Without the macro, m_rresp SHALL be ignored, m_rdata is always loaded, and err_o is tied 0.

Verification
REQ-036 Cold miss: rst then ce=1, addr=0x0000_0000; arready and rvalid returned immediately, rdata=0x3401_0020 -> arvalid in cycle 1, stall high cycles 0-2, rom_data_o=0x3401_0020 and stall low in cycle 3.
REQ-037 Hit: hold addr=0x0000_0000 for 5 cycles after the fill -> no further arvalid, stall_req_o=0, and data stable.
REQ-038 Backpressure: arready delayed 4 cycles, rvalid delayed 3 cycles, addr=0x0000_0004 -> araddr stable 0x4 throughout, m_rready high only in DATA, and fill occurs on the rvalid cycle.
REQ-039 Address switch mid-flight: addr changes 0x4->0x8 while in DATA -> the 0x4 fill completes, then a new araddr=0x8 appears, and stall stays high until the 0x8 fill.
REQ-040 Reset mid-flight: rst in DATA with rvalid=0 -> arvalid=0 and rready=0 next cycle, vld_q=0, and the next ce re-fetches.
REQ-041 Error (macro defined): rresp=2'b10, rdata=0xDEAD_BEEF -> rom_data_o=0 and err_o=1 sticky; without the macro, rom_data_o=0xDEAD_BEEF and err_o=0.
